// File: rtl/tile_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// tile_cmd_ctrl : button-driven cursor with auto-repeat, plus flag/reveal
//                 command pulses carrying a registered tile index.
// Revision      : 1.0
// ============================================================================
module tile_cmd_ctrl #(
  parameter int GRID_SIZE    = 5,
  parameter int TOTAL_TILES  = GRID_SIZE * GRID_SIZE,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4,
  parameter int WRAP         = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           btn_up,
  input  logic                           btn_down,
  input  logic                           btn_left,
  input  logic                           btn_right,
  input  logic                           btn_flag,
  input  logic                           btn_reveal,
  input  logic                           game_over,
  output logic [$clog2(GRID_SIZE)-1:0]   cursor_row,
  output logic [$clog2(GRID_SIZE)-1:0]   cursor_col,
  output logic [$clog2(TOTAL_TILES)-1:0] tile_index,
  output logic                           flag,
  output logic                           reveal
);

  localparam int c_rw      = $clog2(GRID_SIZE);
  localparam int c_iw      = $clog2(TOTAL_TILES);
  localparam int c_cnt_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_cw      = $clog2(c_cnt_max + 1);

  localparam logic [c_rw-1:0] c_last      = c_rw'(GRID_SIZE - 1);
  localparam logic [c_rw:0]   c_grid_ext  = (c_rw + 1)'(GRID_SIZE);
  localparam logic [c_iw-1:0] c_grid_iw   = c_iw'(GRID_SIZE);
  localparam logic [c_cw-1:0] c_delay_end = c_cw'(REPEAT_DELAY - 1);
  localparam logic [c_cw-1:0] c_rate_end  = c_cw'(REPEAT_RATE - 1);
  localparam bit              c_wrap      = (WRAP != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    D_NONE  = 3'd0,
    D_UP    = 3'd1,
    D_DOWN  = 3'd2,
    D_LEFT  = 3'd3,
    D_RIGHT = 3'd4
  } dir_t;

  state_t            r_state, w_state_nxt;
  dir_t              r_dir, w_dir;
  logic [c_cw-1:0]   r_cnt, w_cnt_nxt;
  logic              w_step;

  logic [c_rw-1:0]   r_row, r_col, w_row_nxt, w_col_nxt;
  logic [c_rw:0]     w_row_dec, w_row_inc, w_col_dec, w_col_inc;
  logic [c_iw-1:0]   r_idx, w_idx;
  logic              r_prev_flag, r_prev_reveal;
  logic              r_flag, r_reveal;
  logic              w_flag_go, w_reveal_go;

  // Highest-priority held direction; a change of it counts as a fresh press.
  always_comb begin
    w_dir = D_NONE;
    if (btn_up)         w_dir = D_UP;
    else if (btn_down)  w_dir = D_DOWN;
    else if (btn_left)  w_dir = D_LEFT;
    else if (btn_right) w_dir = D_RIGHT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step      = 1'b0;
    if (w_dir == D_NONE) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (w_dir != r_dir) begin
      w_step      = 1'b1;
      w_state_nxt = S_DELAY;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_DELAY: begin
          if (r_cnt == c_delay_end) begin
            w_step      = 1'b1;
            w_state_nxt = S_REPEAT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_REPEAT: begin
          if (r_cnt == c_rate_end) begin
            w_step    = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          // Direction held through reset without a new edge: stay idle.
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // One extra bit exposes underflow below 0 and overflow at GRID_SIZE.
  assign w_row_dec = {1'b0, r_row} - 1'b1;
  assign w_row_inc = {1'b0, r_row} + 1'b1;
  assign w_col_dec = {1'b0, r_col} - 1'b1;
  assign w_col_inc = {1'b0, r_col} + 1'b1;

  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    if (w_step) begin
      case (w_dir)
        D_UP:    w_row_nxt = w_row_dec[c_rw] ? (c_wrap ? c_last : r_row)
                                             : w_row_dec[c_rw-1:0];
        D_DOWN:  w_row_nxt = (w_row_inc == c_grid_ext) ? (c_wrap ? '0 : r_row)
                                                       : w_row_inc[c_rw-1:0];
        D_LEFT:  w_col_nxt = w_col_dec[c_rw] ? (c_wrap ? c_last : r_col)
                                             : w_col_dec[c_rw-1:0];
        D_RIGHT: w_col_nxt = (w_col_inc == c_grid_ext) ? (c_wrap ? '0 : r_col)
                                                       : w_col_inc[c_rw-1:0];
        default: begin
          w_row_nxt = r_row;
          w_col_nxt = r_col;
        end
      endcase
    end
  end

  assign w_idx       = c_iw'(r_row) * c_grid_iw + c_iw'(r_col);
  assign w_flag_go   = btn_flag & ~r_prev_flag & ~game_over;
  assign w_reveal_go = btn_reveal & ~r_prev_reveal & ~game_over & ~w_flag_go;

  // Histories load during reset too, so a button held through reset never fires.
  always_ff @(posedge clk) begin
    r_prev_flag   <= btn_flag;
    r_prev_reveal <= btn_reveal;
    r_dir         <= w_dir;
    if (rst) begin
      r_row    <= '0;
      r_col    <= '0;
      r_idx    <= '0;
      r_flag   <= 1'b0;
      r_reveal <= 1'b0;
    end else begin
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_flag   <= w_flag_go;
      r_reveal <= w_reveal_go;
      if (w_flag_go || w_reveal_go) begin
        r_idx <= w_idx;
      end
    end
  end

  assign cursor_row = r_row;
  assign cursor_col = r_col;
  assign tile_index = r_idx;
  assign flag       = r_flag;
  assign reveal     = r_reveal;

endmodule
`default_nettype wire

// File: tb/tb_tile_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// tb_tile_cmd_ctrl : directed and randomized checks of tile_cmd_ctrl (wrap and
//                    saturate builds) against a cycle-count reference model.
// Revision         : 1.0
// ============================================================================
module tb_tile_cmd_ctrl;

  localparam int G = 5;
  localparam int D = 16;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst, btn_up, btn_down, btn_left, btn_right, btn_flag, btn_reveal, game_over;
  logic [2:0] row_w, col_w, row_s, col_s;
  logic [4:0] idx_w, idx_s;
  logic       flag_w, reveal_w, flag_s, reveal_s;

  int total = 0;
  int bad   = 0;

  // Reference model state: index 0 = wrapping build, index 1 = saturating build
  int m_row[2], m_col[2], m_idx[2];
  bit m_flag, m_reveal, m_pf, m_pr, m_moving;
  int m_dprev, m_held, md;
  bit mst, mfp, mrp;

  tile_cmd_ctrl #(.GRID_SIZE(G), .REPEAT_DELAY(D), .REPEAT_RATE(R), .WRAP(1)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_flag(btn_flag), .btn_reveal(btn_reveal),
    .game_over(game_over), .cursor_row(row_w), .cursor_col(col_w),
    .tile_index(idx_w), .flag(flag_w), .reveal(reveal_w));

  tile_cmd_ctrl #(.GRID_SIZE(G), .REPEAT_DELAY(D), .REPEAT_RATE(R), .WRAP(0)) dut_sat (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_flag(btn_flag), .btn_reveal(btn_reveal),
    .game_over(game_over), .cursor_row(row_s), .cursor_col(col_s),
    .tile_index(idx_s), .flag(flag_s), .reveal(reveal_s));

  always #5 clk = ~clk;

  function automatic int dir_of(input logic u, input logic d, input logic l, input logic r);
    if (u) return 1;
    if (d) return 2;
    if (l) return 3;
    if (r) return 4;
    return 0;
  endfunction

  function automatic int mv(input int v, input int delta, input int wrap);
    int n;
    n = v + delta;
    if (n < 0)       n = (wrap != 0) ? G - 1 : 0;
    else if (n >= G) n = (wrap != 0) ? 0 : G - 1;
    return n;
  endfunction

  // Model: steps at the fresh press, then at D cycles held, then every R cycles.
  always @(posedge clk) begin
    md  = dir_of(btn_up, btn_down, btn_left, btn_right);
    mfp = btn_flag && !m_pf && !game_over;
    mrp = btn_reveal && !m_pr && !game_over;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_row[i] = 0; m_col[i] = 0; m_idx[i] = 0;
      end
      m_flag = 0; m_reveal = 0; m_moving = 0; m_held = 0;
    end else begin
      m_flag   = mfp;
      m_reveal = mrp && !mfp;
      if (mfp || mrp)
        for (int i = 0; i < 2; i++) m_idx[i] = m_row[i] * G + m_col[i];
      mst = 0;
      if (md == 0) begin
        m_moving = 0; m_held = 0;
      end else if (md != m_dprev) begin
        mst = 1; m_moving = 1; m_held = 0;
      end else if (m_moving) begin
        m_held++;
        if (m_held >= D && ((m_held - D) % R) == 0) mst = 1;
      end
      if (mst) begin
        for (int i = 0; i < 2; i++) begin
          case (md)
            1: m_row[i] = mv(m_row[i], -1, (i == 0) ? 1 : 0);
            2: m_row[i] = mv(m_row[i],  1, (i == 0) ? 1 : 0);
            3: m_col[i] = mv(m_col[i], -1, (i == 0) ? 1 : 0);
            default: m_col[i] = mv(m_col[i], 1, (i == 0) ? 1 : 0);
          endcase
        end
      end
    end
    m_pf    = btn_flag;
    m_pr    = btn_reveal;
    m_dprev = md;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_dir(input int d, input logic v);
    case (d)
      1: btn_up = v;
      2: btn_down = v;
      3: btn_left = v;
      default: btn_right = v;
    endcase
  endtask

  task automatic tap(input int d);
    set_dir(d, 1'b1); tick();
    set_dir(d, 1'b0); tick();
  endtask

  task automatic do_reset();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    btn_flag = 0; btn_reveal = 0; game_over = 0;
    rst = 1; tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; btn_right = 1;
    tick(); tick();
    total++;
    if (row_w !== 3'd0 || col_w !== 3'd0 || idx_w !== 5'd0 || flag_w !== 1'b0 || reveal_w !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: row=%0d col=%0d idx=%0d flag=%0b reveal=%0b, required all 0",
               row_w, col_w, idx_w, flag_w, reveal_w);
    end
    rst = 0; tick(); tick();
    total++;
    if (row_w !== 3'd0 || col_w !== 3'd0) begin
      bad++;
      $display("FAIL held_through_reset: row=%0d col=%0d, required 0 0", row_w, col_w);
    end
    btn_right = 0; tick();
    btn_right = 1; tick();
    total++;
    if (col_w !== 3'd1) begin
      bad++;
      $display("FAIL first_right: col=%0d, required 1", col_w);
    end
    btn_right = 0; tick();
  endtask

  task automatic test_hold();
    logic [2:0] exp_w;
    do_reset();
    btn_down = 1; tick();
    total++;
    if (row_w !== 3'd1 || row_s !== 3'd1) begin
      bad++;
      $display("FAIL hold_press_step: row_w=%0d row_s=%0d, required 1", row_w, row_s);
    end
    repeat (15) tick();
    total++;
    if (row_w !== 3'd1 || row_s !== 3'd1) begin
      bad++;
      $display("FAIL hold_before_delay: row_w=%0d row_s=%0d, required 1", row_w, row_s);
    end
    tick();
    total++;
    if (row_w !== 3'd2 || row_s !== 3'd2) begin
      bad++;
      $display("FAIL hold_delay_step: row_w=%0d row_s=%0d, required 2", row_w, row_s);
    end
    for (int k = 3; k <= 6; k++) begin
      repeat (3) tick();
      total++;
      if (row_w !== 3'((k - 1) % G) || row_s !== 3'((k - 1 > 4) ? 4 : k - 1)) begin
        bad++;
        $display("FAIL hold_rate_early: step=%0d row_w=%0d row_s=%0d, required %0d %0d",
                 k, row_w, row_s, (k - 1) % G, (k - 1 > 4) ? 4 : k - 1);
      end
      tick();
      exp_w = 3'(k % G);
      total++;
      if (row_w !== exp_w || row_s !== 3'((k > 4) ? 4 : k)) begin
        bad++;
        $display("FAIL hold_rate_step: step=%0d row_w=%0d row_s=%0d, required %0d %0d",
                 k, row_w, row_s, exp_w, (k > 4) ? 4 : k);
      end
    end
    btn_down = 0; tick();
  endtask

  task automatic test_flag();
    int cnt;
    do_reset();
    tap(2); tap(2); tap(4); tap(4); tap(4);
    total++;
    if (row_w !== 3'd2 || col_w !== 3'd3) begin
      bad++;
      $display("FAIL flag_setup: row=%0d col=%0d, required 2 3", row_w, col_w);
    end
    btn_flag = 1; tick();
    total++;
    if (flag_w !== 1'b1 || idx_w !== 5'd13 || reveal_w !== 1'b0) begin
      bad++;
      $display("FAIL flag_pulse: flag=%0b idx=%0d reveal=%0b, required 1 13 0", flag_w, idx_w, reveal_w);
    end
    cnt = 0;
    repeat (50) begin
      tick();
      if (flag_w) cnt++;
    end
    total++;
    if (cnt != 0 || idx_w !== 5'd13) begin
      bad++;
      $display("FAIL flag_no_repeat: extra_pulses=%0d idx=%0d, required 0 13", cnt, idx_w);
    end
    btn_flag = 0; tick();
  endtask

  task automatic test_both();
    int cnt;
    do_reset();
    tap(2); tap(4);
    btn_flag = 1; btn_reveal = 1; tick();
    total++;
    if (flag_w !== 1'b1 || idx_w !== 5'd6 || reveal_w !== 1'b0) begin
      bad++;
      $display("FAIL both_flag_wins: flag=%0b idx=%0d reveal=%0b, required 1 6 0", flag_w, idx_w, reveal_w);
    end
    cnt = 0;
    repeat (10) begin
      tick();
      if (reveal_w) cnt++;
    end
    total++;
    if (cnt != 0) begin
      bad++;
      $display("FAIL both_reveal_dropped: reveal_pulses=%0d, required 0", cnt);
    end
    btn_flag = 0; btn_reveal = 0; tick();
  endtask

  task automatic test_cmd_move();
    do_reset();
    tap(4); tap(4);
    btn_reveal = 1; btn_left = 1; tick();
    total++;
    if (reveal_w !== 1'b1 || idx_w !== 5'd2 || col_w !== 3'd1 || flag_w !== 1'b0) begin
      bad++;
      $display("FAIL cmd_with_move: reveal=%0b idx=%0d col=%0d flag=%0b, required 1 2 1 0",
               reveal_w, idx_w, col_w, flag_w);
    end
    btn_reveal = 0; btn_left = 0; tick();
    total++;
    if (reveal_w !== 1'b0 || idx_w !== 5'd2) begin
      bad++;
      $display("FAIL cmd_one_cycle: reveal=%0b idx=%0d, required 0 2", reveal_w, idx_w);
    end
  endtask

  task automatic test_game_over();
    int cnt;
    do_reset();
    game_over = 1; btn_reveal = 1; tick();
    total++;
    if (reveal_w !== 1'b0 || idx_w !== 5'd0) begin
      bad++;
      $display("FAIL gameover_suppress: reveal=%0b idx=%0d, required 0 0", reveal_w, idx_w);
    end
    btn_right = 1; tick();
    total++;
    if (col_w !== 3'd1) begin
      bad++;
      $display("FAIL gameover_move: col=%0d, required 1", col_w);
    end
    btn_right = 0; tick();
    game_over = 0;
    cnt = 0;
    repeat (5) begin
      tick();
      if (reveal_w) cnt++;
    end
    total++;
    if (cnt != 0) begin
      bad++;
      $display("FAIL gameover_release_held: reveal_pulses=%0d, required 0", cnt);
    end
    btn_reveal = 0; tick();
    btn_reveal = 1; tick();
    total++;
    if (reveal_w !== 1'b1 || idx_w !== 5'd1) begin
      bad++;
      $display("FAIL gameover_next_press: reveal=%0b idx=%0d, required 1 1", reveal_w, idx_w);
    end
    btn_reveal = 0; tick();
  endtask

  task automatic test_random();
    int shown;
    shown = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) btn_up     = ~btn_up;
      if ($urandom_range(15) == 0) btn_down   = ~btn_down;
      if ($urandom_range(15) == 0) btn_left   = ~btn_left;
      if ($urandom_range(15) == 0) btn_right  = ~btn_right;
      if ($urandom_range(7)  == 0) btn_flag   = ~btn_flag;
      if ($urandom_range(7)  == 0) btn_reveal = ~btn_reveal;
      if ($urandom_range(49) == 0) game_over  = ~game_over;
      rst = ($urandom_range(499) == 0);
      tick();
      total++;
      if (row_w !== 3'(m_row[0]) || col_w !== 3'(m_col[0]) || idx_w !== 5'(m_idx[0]) ||
          flag_w !== m_flag || reveal_w !== m_reveal) begin
        bad++;
        if (shown < 20)
          $display("FAIL random_wrap c=%0d: got r%0d c%0d i%0d f%0b v%0b, required r%0d c%0d i%0d f%0b v%0b",
                   c, row_w, col_w, idx_w, flag_w, reveal_w, m_row[0], m_col[0], m_idx[0], m_flag, m_reveal);
        shown++;
      end
      total++;
      if (row_s !== 3'(m_row[1]) || col_s !== 3'(m_col[1]) || idx_s !== 5'(m_idx[1]) ||
          flag_s !== m_flag || reveal_s !== m_reveal) begin
        bad++;
        if (shown < 20)
          $display("FAIL random_sat c=%0d: got r%0d c%0d i%0d f%0b v%0b, required r%0d c%0d i%0d f%0b v%0b",
                   c, row_s, col_s, idx_s, flag_s, reveal_s, m_row[1], m_col[1], m_idx[1], m_flag, m_reveal);
        shown++;
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    btn_flag = 0; btn_reveal = 0; game_over = 0;
    test_reset();
    test_hold();
    test_flag();
    test_both();
    test_cmd_move();
    test_game_over();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
